addrev: RTL and testbench



---
 rtl/adder_pkg.sv | 7 +
 rtl/addrev_if.sv | 17 +
 rtl/addrev_full_adder.sv | 16 +
 rtl/addrev.sv | 47 ++++
 tb/tb_addrev.sv | 133 +++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder4 arithmetic leaves.
// Latency: n/a (types and constants only).
// Backpressure: none.
package adder_pkg;
    localparam int ADD_WIDTH = 4;
    typedef logic [ADD_WIDTH-1:0] nibble_t;
endpackage

// File: rtl/addrev_if.sv
// Operand/result bundle for the registered adder.
// Latency: n/a (wiring only).
// Backpressure: none; results follow operands by one clock, no handshake.
interface addrev_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             cout;
    logic             ovf;

    modport master (output a, output b, input c, input cout, input ovf);
    modport slave  (input a, input b, output c, output cout, output ovf);
endinterface

// File: rtl/addrev_full_adder.sv
// One-bit full adder, the ripple-chain cell.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);
endmodule

// File: rtl/addrev.sv
// Registered ripple-carry adder with carry-out and signed-overflow flags.
// Latency: 1 cycle, one add per cycle.
// Backpressure: none; inputs are re-sampled on every rising clk.
module addrev
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    addrev_if.slave  bus
);
    logic [WIDTH:0]   w_k;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_c;
    logic             r_cout;
    logic             r_ovf;

    assign w_k[0] = 1'b0;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        full_adder u_fa (
            .a    (bus.a[gi]),
            .b    (bus.b[gi]),
            .cin  (w_k[gi]),
            .s    (w_s[gi]),
            .cout (w_k[gi+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_c    <= w_s;
            r_cout <= w_k[WIDTH];
            r_ovf  <= w_k[WIDTH] ^ w_k[WIDTH-1];
        end
    end

    assign bus.c    = r_c;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_addrev.sv
// Randomized and exhaustive scoreboard bench for addrev.
module tb_addrev;
    import adder_pkg::*;

    typedef struct {
        nibble_t a;
        nibble_t b;
        nibble_t c;
        logic    cout;
        logic    ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    exp_t q[$];

    addrev_if #(.WIDTH(4)) u_if ();

    addrev u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference: plain integer arithmetic, signed range check for ovf.
    function automatic exp_t model(input nibble_t a, input nibble_t b);
        exp_t e;
        int   su, sa, sb, ss;
        su = int'(a) + int'(b);
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        ss = sa + sb;
        e.a    = a;
        e.b    = b;
        e.c    = nibble_t'(su % 16);
        e.cout = (su >= 16);
        e.ovf  = (ss > 7) || (ss < -8);
        return e;
    endfunction

    task automatic drive(input nibble_t a, input nibble_t b);
        @(negedge clk);
        u_if.a = a;
        u_if.b = b;
        q.push_back(model(a, b));
    endtask

    // Monitor: each expected result is due one edge after it was pushed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("sum a=%0h b=%0h", e.a, e.b), int'(u_if.c), int'(e.c));
                chk($sformatf("cout a=%0h b=%0h", e.a, e.b), int'(u_if.cout), int'(e.cout));
                chk($sformatf("ovf a=%0h b=%0h", e.a, e.b), int'(u_if.ovf), int'(e.ovf));
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        u_if.a  = 4'hF;
        u_if.b  = 4'hF;
        repeat (2) @(posedge clk);

        // Async reset with no clock edge, then held across edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset async c", int'(u_if.c), 0);
        chk("reset async cout", int'(u_if.cout), 0);
        chk("reset async ovf", int'(u_if.ovf), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset hold c", int'(u_if.c), 0);
            chk("reset hold flags", int'({u_if.cout, u_if.ovf}), 0);
        end
        rst = 1'b0;

        drive(4'h0, 4'h0);
        drive(4'h0, 4'h6);
        drive(4'h9, 4'h8);
        drive(4'h7, 4'h1);

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                drive(nibble_t'(ia), nibble_t'(ib));

        repeat (200) drive(nibble_t'($urandom_range(15)), nibble_t'($urandom_range(15)));

        // Reset mid-stream: the loaded 5+5 is discarded asynchronously.
        drive(4'h5, 4'h5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midstream reset c", int'(u_if.c), 0);
        chk("midstream reset flags", int'({u_if.cout, u_if.ovf}), 0);
        @(posedge clk);
        #1;
        chk("midstream hold c", int'(u_if.c), 0);
        rst = 1'b0;
        drive(4'h5, 4'h5);

        repeat (50) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
